// File: rtl/pc_branch_ctrl_pkg.sv
// Shared definitions for the PC / flag / branch control unit:
// condition-code values, flag bit positions and the run/halt state type.
package pc_branch_ctrl_pkg;

  // Branch condition codes carried in the B/BR instruction
  localparam logic [2:0] COND_NE     = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_OV     = 3'b110;
  localparam logic [2:0] COND_ALWAYS = 3'b111;

  // Bit positions inside the 3-bit flag vector
  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_W = 3;

  // Core execution state; HALT is only left through reset
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/pc_branch_ctrl_branch_cond_eval.sv
// branch_cond_eval: purely combinational evaluation of a 3-bit branch
// condition against the N/V/Z flags. Kept stand-alone so a pipelined core
// can reuse it without the PC logic.
module branch_cond_eval
  import pc_branch_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic flag_n;
  logic flag_v;
  logic flag_z;

  assign flag_n = flags[FLAG_N];
  assign flag_v = flags[FLAG_V];
  assign flag_z = flags[FLAG_Z];

  // Decode the condition code into a single taken/not-taken decision
  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      COND_NE:     cond_true = !flag_z;
      COND_EQ:     cond_true = flag_z;
      COND_GT:     cond_true = !flag_z && !flag_n;
      COND_LT:     cond_true = flag_n;
      COND_GE:     cond_true = flag_z || (!flag_z && !flag_n);
      COND_LE:     cond_true = flag_n || flag_z;
      COND_OV:     cond_true = flag_v;
      COND_ALWAYS: cond_true = 1'b1;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: program counter, N/V/Z flag register and HALT state for
// the 16-bit single-cycle core. Branches resolve combinationally against the
// registered flags; the chosen next PC is registered on the following edge.
// Optional feature macro: BRANCH_STATS_EN adds a saturating taken-branch
// counter on output br_taken_cnt.
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      alu_flag,
  input  logic [2:0]      flag_upd,
  input  logic            stall,
  input  logic            is_b,
  input  logic            is_br,
  input  logic            is_hlt,
  input  logic [2:0]      cond,
  input  logic [8:0]      imm9,
  input  logic [PC_W-1:0] rs_val,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic [2:0]      flags,
  output logic            taken,
  output logic            halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     br_taken_cnt
`endif
);

  state_e            state_reg;
  state_e            state_next;
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   pc_next;
  logic [2:0]        flags_reg;
  logic [2:0]        flags_next;
  logic              cond_true;
  logic              run_en;
  logic [PC_W-1:0]   b_offset;
  logic [PC_W-1:0]   br_target;

  // Work only happens in RUN on a non-stalled cycle
  assign run_en = (state_reg == ST_RUN) && !stall;

  // Word offset sign-extended and scaled to bytes; BR target forced even
  assign b_offset  = {{(PC_W-10){imm9[8]}}, imm9, 1'b0};
  assign br_target = rs_val & ~PC_W'(1);
  assign pc_plus2  = pc_reg + PC_W'(2);

  branch_cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (flags_reg),
    .cond_true (cond_true)
  );

  // Per-bit flag write enables: only enabled bits take the ALU value
  for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_flag
    assign flags_next[gi] = (run_en && flag_upd[gi]) ? alu_flag[gi] : flags_reg[gi];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  // Next-state logic: HLT is accepted only when not stalled; HALT absorbs
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_RUN && !stall && is_hlt) state_next = ST_HALT;
  end

  // Output logic: branch decision and next-PC selection (is_b wins over is_br)
  always_comb begin
    taken   = (is_b || is_br) && cond_true && (state_reg == ST_RUN);
    pc_next = pc_reg;
    if (run_en && !is_hlt) begin
      if (taken && is_b)       pc_next = pc_plus2 + b_offset;
      else if (taken && is_br) pc_next = br_target;
      else                     pc_next = pc_plus2;
    end
  end

  // PC and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      flags_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      flags_reg <= flags_next;
    end
  end

  assign pc     = pc_reg;
  assign flags  = flags_reg;
  assign halted = (state_reg == ST_HALT);

`ifdef BRANCH_STATS_EN
  logic [15:0] br_cnt_reg;

  // Saturating count of taken branches on non-stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     br_cnt_reg <= '0;
    else if (taken && !stall && br_cnt_reg != '1)   br_cnt_reg <= br_cnt_reg + 16'd1;
  end

  assign br_taken_cnt = br_cnt_reg;
`endif

endmodule

// File: doc/pc_branch_ctrl.md
# pc_branch_ctrl

Program-counter and flag-register unit for the 16-bit single-cycle processor. It registers the N/V/Z flags produced by the ALU and evaluates the 3-bit branch condition of B/BR against them. It then selects and registers the next PC and holds the core in HALT after HLT. It sits between the ALU/decoder and instruction fetch, and closes the loop from ALU flag generation to control flow.

## Interface
- PC_W, 16, PC and register-operand width
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_flag  in  3  ALU flags: [0]=N, [1]=V, [2]=Z
- flag_upd  in  3  per-bit flag write enable, same bit order; decoder drives 111 for ADD/SUB, 100 for XOR/SLL/SRL/ROR, 000 otherwise
- stall  in  1  freeze PC, flags, state
- is_b  in  1  current instruction is B (PC-relative)
- is_br  in  1  current instruction is BR (register target)
- is_hlt  in  1  current instruction is HLT
- cond  in  3  branch condition code
- imm9  in  9  signed word offset for B
- rs_val  in  PC_W  target register value for BR
- pc  out  PC_W  registered current PC
- pc_plus2  out  PC_W  combinational pc+2
- flags  out  3  registered flags, same bit order as alu_flag
- taken  out  1  combinational: branch taken this cycle
- halted  out  1  registered, 1 in HALT

## Operation
- Condition codes: 000 NE (Z=0); 001 EQ (Z=1); 010 GT (Z=0 & N=0); 011 LT (N=1); 100 GE (Z=1 | (Z=0 & N=0)); 101 LE (N=1 | Z=1); 110 OV (V=1); 111 always.
- taken = (is_b | is_br) & cond_true(flags) & state==RUN. The condition is evaluated on the registered flags only.
- Next PC priority:
  - HALT or stall: hold.
  - is_hlt: hold, enter HALT.
  - taken & is_b: pc_plus2 + (sext(imm9) << 1).
  - taken & is_br: {rs_val[15:1], 1'b0}.
  - Otherwise: pc_plus2.
- All PC arithmetic is modulo 2^16. 0xFFFE + 2 = 0x0000. Negative offsets wrap the same way.
- Flag register: on a clock edge in RUN with !stall, each bit i with flag_upd[i]=1 loads alu_flag[i]. Other bits hold.
- FSM states:
  - RUN: on is_hlt & !stall, go to HALT.
  - HALT: absorbing. Ignores all inputs and stall. Exits only on rst_n low.
- is_b and is_br both asserted is illegal from the decoder. is_b takes priority.

## Timing
- Reset (async, rst_n=0): pc=RESET_PC, flags=000, halted=0, state RUN, and br_taken_cnt=0 if compiled in. Reset applies immediately, including mid-operation and from HALT.
- Fetch address pc is valid one cycle after reset deassertion. The first edge with rst_n=1 advances to RESET_PC+2 unless stalled.
- Branch resolution has zero-cycle latency. taken and the next PC are combinational in the same cycle, and the new pc appears after the next edge. There are no delay slots.
- A flag-setting instruction at cycle t is visible to a branch at cycle t+1.
- stall has a one-cycle effect per asserted cycle. HLT is accepted on the first non-stalled cycle.

## Configuration
- BRANCH_STATS_EN
  - Defined: adds output br_taken_cnt (16 bits). It increments on each clock edge where taken & !stall, saturates at 0xFFFF, and resets to 0.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - condition-code constants (COND_NE..COND_ALWAYS);
  - flag bit indices (FLAG_N=0, FLAG_V=1, FLAG_Z=2);
  - the RUN/HALT state enum.
- One sub-module, branch_cond_eval: combinational, inputs cond and flags, output cond_true. It is reused by a later pipelined core.

## Test plan
- Reset: pulse rst_n low mid-run while pc=0x0040 -> pc=0x0000, flags=000, halted=0 without a clock edge.
- Sequential fetch: 4 unstalled cycles, no branch -> pc 0x0000, 0x0002, 0x0004, 0x0006, 0x0008.
- B with EQ and NE at pc=0x0010:
  - Setup: flag_upd=111, alu_flag=100 sets flags=100.
  - B cond=001, imm9=0x1FE -> taken=1, next pc=0x000E.
  - Same setup with cond=000 -> taken=0, next pc=0x0012.
- Partial flag update:
  - flags=011, then flag_upd=100, alu_flag=100 -> flags=111.
  - Then flag_upd=000 with any alu_flag -> flags hold at 111.
- BR and wrap:
  - BR cond=111, rs_val=0x1235 -> pc=0x1234.
  - pc=0xFFFE, no branch -> pc=0x0000.
  - B imm9=0x0FF at pc=0xFF00 -> pc=0x0100.
- Halt, stall and stats:
  - is_hlt with stall=1 -> no change.
  - stall=0 -> halted=1, pc frozen for 10 cycles regardless of inputs, released only by rst_n.
  - With BRANCH_STATS_EN defined: 3 taken and 2 not-taken branches -> br_taken_cnt=3.
